// File: rtl/crdma_dim3_if.sv
// Bundle of descriptor, address, read-return and stream-out handshakes for crdma_dim3.
// master is the DMA engine side; slave is the system/testbench side.
interface crdma_dim3_if #(
  parameter int AW = 32,
  parameter int DW = 64,
  parameter int SW = 8
) ();
  logic [AW-1:0] desc_base;
  logic [SW-1:0] desc_dim0_size;
  logic [SW-1:0] desc_dim0_step;
  logic [SW-1:0] desc_dim1_size;
  logic [SW-1:0] desc_dim1_step;
  logic [SW-1:0] desc_dim2_size;
  logic [SW-1:0] desc_dim2_step;
  logic          desc_valid;
  logic          desc_ready;

  logic [AW-1:0] addr;
  logic          addr_first;
  logic          addr_last;
  logic          addr_valid;
  logic          addr_ready;

  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;

  logic [DW-1:0] s_data;
  logic          s_first;
  logic          s_last;
  logic          s_valid;
  logic          s_ready;

  modport master (
    input  desc_base, desc_dim0_size, desc_dim0_step, desc_dim1_size,
           desc_dim1_step, desc_dim2_size, desc_dim2_step, desc_valid,
    output desc_ready,
    output addr, addr_first, addr_last, addr_valid,
    input  addr_ready,
    input  m_data, m_valid,
    output m_ready,
    output s_data, s_first, s_last, s_valid,
    input  s_ready
  );

  modport slave (
    output desc_base, desc_dim0_size, desc_dim0_step, desc_dim1_size,
           desc_dim1_step, desc_dim2_size, desc_dim2_step, desc_valid,
    input  desc_ready,
    input  addr, addr_first, addr_last, addr_valid,
    output addr_ready,
    output m_data, m_valid,
    input  m_ready,
    input  s_data, s_first, s_last, s_valid,
    output s_ready
  );
endinterface

// File: rtl/crdma_dim3.sv
// 3-D strided read DMA: walks a descriptor's address space and streams returned data in order.
// Define CRDMA_DIM3_PERF_EN to add saturating busy/stall cycle counters.
module crdma_dim3 #(
  parameter int AW    = 32,
  parameter int DW    = 64,
  parameter int SW    = 8,
  parameter int MAXOS = 8
) (
  input  logic               clk,
  input  logic               rst,
  crdma_dim3_if.master       bus,
  output logic               busy
`ifdef CRDMA_DIM3_PERF_EN
  ,
  output logic [31:0]        perf_busy_cyc,
  output logic [31:0]        perf_stall_cyc
`endif
);

  localparam int TW = 3 * SW;
  localparam logic [7:0] MAXOS_L = 8'(MAXOS);

  typedef enum logic [1:0] {IDLE, GEN, DRAIN} state_t;

  state_t        state;
  state_t        state_nxt;

  logic [SW-1:0] sz0, sz1, sz2;
  logic [SW-1:0] st0, st1, st2;
  logic [SW-1:0] i0, i1, i2;
  logic [AW-1:0] addr_cur;
  logic [AW-1:0] row_base;
  logic [AW-1:0] plane_base;
  logic          first_pend;
  logic [TW-1:0] tot_m1;
  logic [TW-1:0] ret_cnt;
  logic [7:0]    outst;

  logic          desc_hs;
  logic          addr_hs;
  logic          s_hs;
  logic          at_last;
  logic [TW-1:0] ext0, ext1, ext2;
  logic [TW-1:0] tot_m1_nxt;
  logic [DW-1:0] ret_data;

  assign desc_hs = bus.desc_valid & bus.desc_ready;
  assign addr_hs = bus.addr_valid & bus.addr_ready;
  assign s_hs    = bus.s_valid & bus.s_ready;
  assign at_last = (i0 == sz0) && (i1 == sz1) && (i2 == sz2);

  // Beat count minus one; the product may wrap to zero at the maximum, and the -1 still lands right.
  assign ext0       = TW'(bus.desc_dim0_size) + TW'(1);
  assign ext1       = TW'(bus.desc_dim1_size) + TW'(1);
  assign ext2       = TW'(bus.desc_dim2_size) + TW'(1);
  assign tot_m1_nxt = (ext0 * ext1 * ext2) - TW'(1);

  assign busy           = (state != IDLE);
  assign bus.desc_ready = (state == IDLE);
  assign bus.addr_valid = (state == GEN) && (outst < MAXOS_L);
  assign bus.addr       = addr_cur;
  assign bus.addr_first = first_pend;
  assign bus.addr_last  = at_last;

  assign ret_data    = bus.m_data;
  assign bus.s_data  = ret_data;
  assign bus.s_valid = bus.m_valid && (state != IDLE);
  assign bus.m_ready = bus.s_ready && (state != IDLE);
  assign bus.s_first = (ret_cnt == '0);
  assign bus.s_last  = (ret_cnt == tot_m1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // The final address and final return may share a cycle, in which case GEN skips DRAIN.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (desc_hs) state_nxt = GEN;
      GEN:   if (addr_hs && at_last) state_nxt = (s_hs && bus.s_last) ? IDLE : DRAIN;
      DRAIN: if (s_hs && bus.s_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address walk keeps running row/plane bases so each step is a single add.
  always_ff @(posedge clk) begin
    if (rst) begin
      sz0 <= '0; sz1 <= '0; sz2 <= '0;
      st0 <= '0; st1 <= '0; st2 <= '0;
      i0 <= '0; i1 <= '0; i2 <= '0;
      addr_cur   <= '0;
      row_base   <= '0;
      plane_base <= '0;
      first_pend <= 1'b0;
      tot_m1     <= '0;
    end else if (desc_hs) begin
      sz0 <= bus.desc_dim0_size; st0 <= bus.desc_dim0_step;
      sz1 <= bus.desc_dim1_size; st1 <= bus.desc_dim1_step;
      sz2 <= bus.desc_dim2_size; st2 <= bus.desc_dim2_step;
      i0 <= '0; i1 <= '0; i2 <= '0;
      addr_cur   <= bus.desc_base;
      row_base   <= bus.desc_base;
      plane_base <= bus.desc_base;
      first_pend <= 1'b1;
      tot_m1     <= tot_m1_nxt;
    end else if (addr_hs) begin
      first_pend <= 1'b0;
      if (i0 != sz0) begin
        i0       <= i0 + SW'(1);
        addr_cur <= addr_cur + AW'(st0);
      end else if (i1 != sz1) begin
        i0       <= '0;
        i1       <= i1 + SW'(1);
        row_base <= row_base + AW'(st1);
        addr_cur <= row_base + AW'(st1);
      end else if (i2 != sz2) begin
        i0         <= '0;
        i1         <= '0;
        i2         <= i2 + SW'(1);
        plane_base <= plane_base + AW'(st2);
        row_base   <= plane_base + AW'(st2);
        addr_cur   <= plane_base + AW'(st2);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ret_cnt <= '0;
      outst   <= '0;
    end else begin
      if (desc_hs)   ret_cnt <= '0;
      else if (s_hs) ret_cnt <= ret_cnt + TW'(1);
      case ({addr_hs, s_hs})
        2'b10:   outst <= outst + 8'd1;
        2'b01:   outst <= outst - 8'd1;
        default: outst <= outst;
      endcase
    end
  end

`ifdef CRDMA_DIM3_PERF_EN
  // Stall counts only throttled GEN cycles, not cycles waiting on addr_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_busy_cyc  <= '0;
      perf_stall_cyc <= '0;
    end else begin
      if (busy && (perf_busy_cyc != '1))
        perf_busy_cyc <= perf_busy_cyc + 32'd1;
      if ((state == GEN) && (outst >= MAXOS_L) && (perf_stall_cyc != '1))
        perf_stall_cyc <= perf_stall_cyc + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_crdma_dim3.sv
// Self-checking bench for crdma_dim3: scoreboarded address walk and in-order data return.
module tb_crdma_dim3;
  localparam int AW    = 32;
  localparam int DW    = 64;
  localparam int SW    = 8;
  localparam int MAXOS = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
`ifdef CRDMA_DIM3_PERF_EN
  logic [31:0] perf_busy_cyc;
  logic [31:0] perf_stall_cyc;
`endif

  always #5 clk = ~clk;

  crdma_dim3_if #(.AW(AW), .DW(DW), .SW(SW)) bus ();

  crdma_dim3 #(.AW(AW), .DW(DW), .SW(SW), .MAXOS(MAXOS)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
`ifdef CRDMA_DIM3_PERF_EN
    ,
    .perf_busy_cyc  (perf_busy_cyc),
    .perf_stall_cyc (perf_stall_cyc)
`endif
  );

  typedef struct {
    logic [31:0] base;
    logic [7:0]  d0, s0, d1, s1, d2, s2;
  } desc_t;
  typedef struct {
    logic [31:0] addr;
    logic        first;
    logic        last;
  } abeat_t;
  typedef struct {
    logic [63:0] data;
    logic        first;
    logic        last;
  } sbeat_t;

  desc_t       pend[$];
  abeat_t      exp_addr[$];
  sbeat_t      exp_beat[$];
  logic [63:0] rq[$];

  int   total = 0;
  int   bad = 0;
  int   ar_pct = 100;
  int   sr_pct = 100;
  int   mv_pct = 100;
  int   addr_hs_cnt = 0;
  int   s_hs_cnt = 0;
  logic last_seen = 1'b0;
  logic idle_mv = 1'b0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected walk from the nested-loop definition of the address space.
  task automatic buildExpected(input desc_t d);
    int     t;
    int     k;
    abeat_t e;
    t = (int'(d.d0) + 1) * (int'(d.d1) + 1) * (int'(d.d2) + 1);
    k = 0;
    for (int i2 = 0; i2 <= int'(d.d2); i2++)
      for (int i1 = 0; i1 <= int'(d.d1); i1++)
        for (int i0 = 0; i0 <= int'(d.d0); i0++) begin
          e.addr  = d.base + 32'(i0) * 32'(d.s0) + 32'(i1) * 32'(d.s1) + 32'(i2) * 32'(d.s2);
          e.first = (k == 0);
          e.last  = (k == t - 1);
          exp_addr.push_back(e);
          k++;
        end
  endtask

  task automatic applyStimulus(input desc_t d);
    pend.push_back(d);
  endtask

  task automatic oneCycle();
    abeat_t      e;
    sbeat_t      b;
    logic [63:0] dat;
    desc_t       d;
    @(negedge clk);
    if (pend.size() > 0) begin
      bus.desc_valid     = 1'b1;
      bus.desc_base      = pend[0].base;
      bus.desc_dim0_size = pend[0].d0;
      bus.desc_dim0_step = pend[0].s0;
      bus.desc_dim1_size = pend[0].d1;
      bus.desc_dim1_step = pend[0].s1;
      bus.desc_dim2_size = pend[0].d2;
      bus.desc_dim2_step = pend[0].s2;
    end else begin
      bus.desc_valid = 1'b0;
    end
    bus.addr_ready = (int'($urandom_range(99, 0)) < ar_pct);
    bus.s_ready    = (int'($urandom_range(99, 0)) < sr_pct);
    if (rq.size() > 0 && int'($urandom_range(99, 0)) < mv_pct) begin
      bus.m_valid = 1'b1;
      bus.m_data  = rq[0];
    end else begin
      bus.m_valid = idle_mv;
      bus.m_data  = {$urandom, $urandom};
    end
    #1;
    if (last_seen) begin
      checkOutput("desc_ready_after_last", 64'(bus.desc_ready), 64'(1));
      last_seen = 1'b0;
    end
    if (exp_beat.size() >= MAXOS)
      checkOutput("maxos_hold", 64'(bus.addr_valid), 64'(0));
    if (bus.addr_valid && bus.addr_ready) begin
      if (exp_addr.size() == 0) begin
        checkOutput("spurious_addr", 64'(bus.addr_valid), 64'(0));
      end else begin
        e = exp_addr.pop_front();
        checkOutput("addr", 64'(bus.addr), 64'(e.addr));
        checkOutput("addr_first", 64'(bus.addr_first), 64'(e.first));
        checkOutput("addr_last", 64'(bus.addr_last), 64'(e.last));
        dat = {$urandom, $urandom};
        rq.push_back(dat);
        b.data  = dat;
        b.first = e.first;
        b.last  = e.last;
        exp_beat.push_back(b);
        addr_hs_cnt++;
      end
    end
    if (bus.s_valid && bus.s_ready) begin
      if (exp_beat.size() == 0) begin
        checkOutput("spurious_s", 64'(bus.s_valid), 64'(0));
      end else begin
        b = exp_beat.pop_front();
        checkOutput("s_data", bus.s_data, b.data);
        checkOutput("s_first", 64'(bus.s_first), 64'(b.first));
        checkOutput("s_last", 64'(bus.s_last), 64'(b.last));
        if (b.last) last_seen = 1'b1;
        s_hs_cnt++;
      end
    end
    if (bus.m_valid && bus.m_ready && rq.size() > 0) void'(rq.pop_front());
    if (bus.desc_valid && bus.desc_ready) begin
      d = pend.pop_front();
      buildExpected(d);
    end
  endtask

  task automatic flushModel();
    pend.delete();
    exp_addr.delete();
    exp_beat.delete();
    rq.delete();
    last_seen = 1'b0;
  endtask

  task automatic runUntilDone(input int budget);
    int n;
    n = 0;
    while ((pend.size() > 0 || exp_addr.size() > 0 || exp_beat.size() > 0 || busy) && n < budget) begin
      oneCycle();
      n++;
    end
    if (n >= budget) begin
      total++;
      bad++;
      $error("[TB] FAIL timeout observed=%0d cycles expected<%0d", n, budget);
      flushModel();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end
  endtask

  initial begin
    desc_t d;
    int    n;
    bus.desc_valid = 1'b0;
    bus.desc_base  = '0;
    bus.desc_dim0_size = '0; bus.desc_dim0_step = '0;
    bus.desc_dim1_size = '0; bus.desc_dim1_step = '0;
    bus.desc_dim2_size = '0; bus.desc_dim2_step = '0;
    bus.addr_ready = 1'b1;
    bus.m_valid    = 1'b1;
    bus.m_data     = '0;
    bus.s_ready    = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_desc_ready", 64'(bus.desc_ready), 64'(1));
    checkOutput("rst_addr_valid", 64'(bus.addr_valid), 64'(0));
    checkOutput("rst_s_valid", 64'(bus.s_valid), 64'(0));
    checkOutput("rst_m_ready", 64'(bus.m_ready), 64'(0));
    checkOutput("rst_busy", 64'(busy), 64'(0));
`ifdef CRDMA_DIM3_PERF_EN
    checkOutput("rst_perf_busy", 64'(perf_busy_cyc), 64'(0));
    checkOutput("rst_perf_stall", 64'(perf_stall_cyc), 64'(0));
`endif
    rst = 1'b0;
    bus.m_valid = 1'b0;

    $display("[TB] 2x4 walk, all ready");
    s_hs_cnt = 0; addr_hs_cnt = 0;
    applyStimulus('{32'h0000_1000, 8'd3, 8'd8, 8'd1, 8'h40, 8'd0, 8'd0});
    runUntilDone(300);
    checkOutput("walk_addr_count", 64'(addr_hs_cnt), 64'(8));
    checkOutput("walk_beat_count", 64'(s_hs_cnt), 64'(8));

    $display("[TB] single beat");
    s_hs_cnt = 0; addr_hs_cnt = 0;
    applyStimulus('{32'h0000_2340, 8'd0, 8'd5, 8'd0, 8'd7, 8'd0, 8'd9});
    runUntilDone(100);
    checkOutput("single_addr_count", 64'(addr_hs_cnt), 64'(1));
    checkOutput("single_beat_count", 64'(s_hs_cnt), 64'(1));

    $display("[TB] outstanding limit with returns held off");
    s_hs_cnt = 0; addr_hs_cnt = 0;
    mv_pct = 0;
    applyStimulus('{32'h0000_8000, 8'd7, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0});
    repeat (10) oneCycle();
    checkOutput("maxos_addr_count", 64'(addr_hs_cnt), 64'(MAXOS));
    checkOutput("maxos_addr_valid", 64'(bus.addr_valid), 64'(0));
    mv_pct = 100;
    runUntilDone(300);
    checkOutput("maxos_total_beats", 64'(s_hs_cnt), 64'(8));

    $display("[TB] address wrap");
    s_hs_cnt = 0; addr_hs_cnt = 0;
    applyStimulus('{32'hFFFF_FFF8, 8'd1, 8'd8, 8'd0, 8'd0, 8'd0, 8'd0});
    runUntilDone(100);
    checkOutput("wrap_beat_count", 64'(s_hs_cnt), 64'(2));

    $display("[TB] reset during address generation");
    addr_hs_cnt = 0;
    applyStimulus('{32'h0000_4000, 8'd7, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0});
    n = 0;
    while (addr_hs_cnt < 3 && n < 50) begin
      oneCycle();
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $error("[TB] FAIL abort_setup observed=%0d addresses expected=3", addr_hs_cnt);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.m_valid = 1'b1;
    bus.s_ready = 1'b1;
    bus.addr_ready = 1'b1;
    bus.desc_valid = 1'b0;
    #1;
    checkOutput("abort_desc_ready", 64'(bus.desc_ready), 64'(1));
    checkOutput("abort_busy", 64'(busy), 64'(0));
    checkOutput("abort_addr_valid", 64'(bus.addr_valid), 64'(0));
    checkOutput("abort_s_valid", 64'(bus.s_valid), 64'(0));
    flushModel();
    idle_mv = 1'b1;
    for (int c = 0; c < 5; c++) begin
      oneCycle();
      checkOutput("idle_no_addr", 64'(bus.addr_valid), 64'(0));
      checkOutput("idle_no_s", 64'(bus.s_valid), 64'(0));
    end
    idle_mv = 1'b0;

    $display("[TB] random back-to-back descriptors with random backpressure");
    ar_pct = 70; sr_pct = 50; mv_pct = 70;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 2; k++) begin
        d.base = $urandom;
        d.d0 = 8'($urandom_range(3, 0)); d.s0 = 8'($urandom);
        d.d1 = 8'($urandom_range(3, 0)); d.s1 = 8'($urandom);
        d.d2 = 8'($urandom_range(2, 0)); d.s2 = 8'($urandom);
        applyStimulus(d);
      end
      runUntilDone(3000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
